// File: rtl/maclaurin_series_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maclaurin_pkg
// Brief    : Shared types, default widths and the elaboration-time Maclaurin
//            coefficient generator. Optional build macro: MACLAURIN_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
package maclaurin_pkg;

    localparam int XW_DEF    = 16;
    localparam int RW_DEF    = 18;
    localparam int CW_DEF    = 20;
    localparam int TERMS_DEF = 8;

    typedef enum logic [1:0] {
        FN_EXP = 2'd0,
        FN_SIN = 2'd1,
        FN_COS = 2'd2,
        FN_LN  = 2'd3
    } func_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    function automatic longint fact(input int n);
        longint r;
        r = 1;
        for (int i = 2; i <= n; i++) r = r * longint'(i);
        return r;
    endfunction

    // Signed Q2.(cw-2) coefficient for term k, rounded to nearest.
    function automatic longint coef(input logic [1:0] fn, input int k, input int cw);
        longint one;
        longint den;
        longint mag;
        logic   neg;
        one = longint'(1) << (cw - 2);
        neg = k[0];
        case (fn)
            FN_EXP:  begin den = fact(k);         neg = 1'b0; end
            FN_SIN:  den = fact(2 * k + 1);
            FN_COS:  den = fact(2 * k);
            default: den = longint'(k + 1);
        endcase
        mag = (one + den / 2) / den;
        return neg ? -mag : mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maclaurin_series_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : maclaurin_series_engine_if
// Brief    : Request/result bundle of the Maclaurin series engine.
//            Optional build macro of the engine: MACLAURIN_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface maclaurin_series_engine_if
    import maclaurin_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int RW = RW_DEF,
    parameter int NW = $clog2(TERMS_DEF + 1)
);
    logic          start;
    logic [XW-1:0] xBus;
    logic [1:0]    func;
    logic [NW-1:0] nTerms;
    logic          busy;
    logic          Done;
    logic [RW-1:0] rBus;

    modport master (output start, xBus, func, nTerms, input  busy, Done, rBus);
    modport slave  (input  start, xBus, func, nTerms, output busy, Done, rBus);
endinterface
`default_nettype wire

// File: rtl/maclaurin_series_engine_coef_rom.sv
`default_nettype none
// ============================================================================
// Module   : maclaurin_coef_rom
// Brief    : Combinational coefficient table, TERMS entries per function,
//            filled at elaboration. Optional build macro: MACLAURIN_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module maclaurin_coef_rom
    import maclaurin_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int TERMS = TERMS_DEF,
    parameter int NW    = $clog2(TERMS + 1)
) (
    input  logic [1:0]           i_func,
    input  logic [NW-1:0]        i_k,
    output logic signed [CW-1:0] o_coef
);
    localparam int KIW = (TERMS > 1) ? $clog2(TERMS) : 1;

    logic signed [CW-1:0] w_table [4][TERMS];

    for (genvar f = 0; f < 4; f++) begin : g_func
        for (genvar t = 0; t < TERMS; t++) begin : g_term
            assign w_table[f][t] = CW'(coef(2'(f), t, CW));
        end
    end

    always_comb begin
        o_coef = '0;
        if (int'(i_k) < TERMS) o_coef = w_table[i_func][i_k[KIW-1:0]];
    end
endmodule
`default_nettype wire

// File: rtl/maclaurin_series_engine.sv
`default_nettype none
// ============================================================================
// Module   : maclaurin_series_engine
// Brief    : Iterative fixed-point exp/sin/cos/ln(1+x) evaluator, one series
//            term per clock. Define MACLAURIN_ROUND_EN for half-up rounding.
// Revision : 1.0 - initial release
// ============================================================================
module maclaurin_series_engine
    import maclaurin_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int RW    = RW_DEF,
    parameter int CW    = CW_DEF,
    parameter int TERMS = TERMS_DEF,
    parameter int NW    = $clog2(TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    maclaurin_series_engine_if.slave bus
);
    localparam int PW  = XW + 1;        // pow/step: unsigned Q1.XW
    localparam int AW  = RW + 2;        // acc: signed Q4.(RW-2)
    localparam int MW  = PW + CW + 1;
    localparam int PPW = 2 * PW;
    localparam int SQW = 2 * XW;
    localparam int SH  = XW + CW - RW;

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_INIT = S_INIT;
    localparam logic [1:0] ST_ITER = S_ITER;
    localparam logic [1:0] ST_FIN  = S_FIN;

    localparam logic [PW-1:0] POW_ONE = {1'b1, {XW{1'b0}}};

`ifdef MACLAURIN_ROUND_EN
    localparam logic signed [MW-1:0] TERM_HALF = MW'(1) << (SH - 1);
    localparam logic [PPW-1:0]       POW_HALF  = PPW'(1) << (XW - 1);
    localparam logic [SQW-1:0]       SQ_HALF   = SQW'(1) << (XW - 1);
`else
    localparam logic signed [MW-1:0] TERM_HALF = '0;
    localparam logic [PPW-1:0]       POW_HALF  = '0;
    localparam logic [SQW-1:0]       SQ_HALF   = '0;
`endif

    logic [1:0]           state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [1:0]           func_q, func_d;
    logic [NW-1:0]        n_q, n_d;
    logic [NW-1:0]        k_q, k_d;
    logic [PW-1:0]        pow_q, pow_d;
    logic [PW-1:0]        step_q, step_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RW-1:0]        rbus_q, rbus_d;

    logic signed [CW-1:0] w_coef;
    logic signed [AW-1:0] w_term;
    logic [PW-1:0]        w_pow_nx;
    logic [XW-1:0]        w_xsq;
    logic [NW-1:0]        w_n_clamped;

    maclaurin_coef_rom #(
        .CW    (CW),
        .TERMS (TERMS),
        .NW    (NW)
    ) u_coef_rom (
        .i_func (func_q),
        .i_k    (k_q),
        .o_coef (w_coef)
    );

    // Operands are widened before multiplying so the full product survives.
    assign w_term   = AW'((MW'($signed({1'b0, pow_q})) * MW'(w_coef) + TERM_HALF) >>> SH);
    assign w_pow_nx = PW'((PPW'(pow_q) * PPW'(step_q) + POW_HALF) >> XW);
    assign w_xsq    = XW'((SQW'(x_q) * SQW'(x_q) + SQ_HALF) >> XW);

    always_comb begin
        w_n_clamped = bus.nTerms;
        if (bus.nTerms == '0)              w_n_clamped = NW'(1);
        else if (bus.nTerms > NW'(TERMS))  w_n_clamped = NW'(TERMS);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        func_d  = func_q;
        n_d     = n_q;
        k_d     = k_q;
        pow_d   = pow_q;
        step_d  = step_q;
        acc_d   = acc_q;
        rbus_d  = rbus_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.xBus;
                    func_d  = bus.func;
                    n_d     = w_n_clamped;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                acc_d = '0;
                k_d   = '0;
                case (func_q)
                    FN_EXP:  begin pow_d = POW_ONE;      step_d = {1'b0, x_q};   end
                    FN_SIN:  begin pow_d = {1'b0, x_q};  step_d = {1'b0, w_xsq}; end
                    FN_COS:  begin pow_d = POW_ONE;      step_d = {1'b0, w_xsq}; end
                    default: begin pow_d = {1'b0, x_q};  step_d = {1'b0, x_q};   end
                endcase
                state_d = ST_ITER;
            end
            ST_ITER: begin
                acc_d = acc_q + w_term;
                pow_d = w_pow_nx;
                k_d   = k_q + NW'(1);
                if (k_q == n_q - NW'(1)) state_d = ST_FIN;
            end
            default: begin
                // Negative sums clamp to zero, anything at or above 4.0 to all-ones.
                if (acc_q[AW-1])            rbus_d = '0;
                else if (|acc_q[AW-2:RW])   rbus_d = '1;
                else                        rbus_d = acc_q[RW-1:0];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            func_q  <= '0;
            n_q     <= '0;
            k_q     <= '0;
            pow_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rbus_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            func_q  <= func_d;
            n_q     <= n_d;
            k_q     <= k_d;
            pow_q   <= pow_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rbus_q  <= rbus_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.Done = done_q;
    assign bus.rBus = rbus_q;
endmodule
`default_nettype wire

// File: tb/tb_maclaurin_series_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_maclaurin_series_engine
// Brief    : Self-checking bench: directed and random runs against a real-valued
//            series model. Engine build macro: MACLAURIN_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maclaurin_series_engine;
    import maclaurin_pkg::*;

    localparam int XW    = 16;
    localparam int RW    = 18;
    localparam int CW    = 20;
    localparam int TERMS = 8;
    localparam int NW    = $clog2(TERMS + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    maclaurin_series_engine_if #(.XW(XW), .RW(RW), .NW(NW)) bus ();

    maclaurin_series_engine #(
        .XW    (XW),
        .RW    (RW),
        .CW    (CW),
        .TERMS (TERMS),
        .NW    (NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    longint spec_q025 [4] = '{64'h148B6, 64'h03F56, 64'h0F80B, 64'h03920};

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
        n_vec++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) +/- %0d",
                     tag, obs, obs, exp, exp, tol);
        end
    endtask

    function automatic int clamp_n(input int nt);
        if (nt == 0) return 1;
        if (nt > TERMS) return TERMS;
        return nt;
    endfunction

    function automatic real rpow(input real b, input int e);
        real r;
        r = 1.0;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic real rfact(input int n);
        real r;
        r = 1.0;
        for (int i = 2; i <= n; i++) r = r * real'(i);
        return r;
    endfunction

    // Ideal partial sum of the series in real arithmetic, scaled to Q2.(RW-2).
    function automatic longint ref_model(input int fn, input int xi, input int nt);
        real x;
        real sum;
        real p;
        real sgn;
        int  n;
        n   = clamp_n(nt);
        x   = real'(xi) / real'(1 << XW);
        sum = 0.0;
        for (int k = 0; k < n; k++) begin
            sgn = (k % 2 == 1) ? -1.0 : 1.0;
            case (fn)
                0:       sum = sum + rpow(x, k) / rfact(k);
                1:       sum = sum + sgn * rpow(x, 2 * k + 1) / rfact(2 * k + 1);
                2:       sum = sum + sgn * rpow(x, 2 * k) / rfact(2 * k);
                default: sum = sum + sgn * rpow(x, k + 1) / real'(k + 1);
            endcase
        end
        p = sum * real'(1 << (RW - 2));
        if (p < 0.0) return 0;
        if (p >= real'(1 << RW)) return longint'((1 << RW) - 1);
        return longint'($rtoi(p + 0.5));
    endfunction

    function automatic longint tol_of(input int nt);
        return longint'(2 * clamp_n(nt) + 3);
    endfunction

    // Called at a falling edge; returns at the falling edge where Done is seen.
    task automatic run_op(input int fn, input int xi, input int nt, input bit spam,
                          output longint res, output int lat);
        lat = -1;
        res = -1;
        bus.start  = 1'b1;
        bus.xBus   = XW'(xi);
        bus.func   = 2'(fn);
        bus.nTerms = NW'(nt);
        @(posedge clk);
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 0) check_val("busy_hi", longint'(bus.busy), 1, 0);
            if (bus.Done) begin
                lat = c;
                res = longint'(bus.rBus);
                check_val("busy_lo_at_done", longint'(bus.busy), 0, 0);
                bus.start = 1'b0;
                break;
            end
            bus.start = spam ? 1'($urandom) : 1'b0;
            if (spam) begin
                bus.xBus   = XW'($urandom);
                bus.func   = 2'($urandom);
                bus.nTerms = NW'($urandom);
            end
            @(posedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint res;
        longint expv;
        int     lat;
        int     n_done;

        bus.start  = 1'b0;
        bus.xBus   = '0;
        bus.func   = '0;
        bus.nTerms = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", longint'(bus.busy), 0, 0);
        check_val("rst_done", longint'(bus.Done), 0, 0);
        check_val("rst_rbus", longint'(bus.rBus), 0, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 4; f++) begin
            run_op(f, 'h4000, 8, 1'b0, res, lat);
            check_val($sformatf("x025_f%0d", f), res, spec_q025[f], 4);
            check_val($sformatf("x025_lat_f%0d", f), longint'(lat), 10, 0);
        end

        run_op(2, 0, 0, 1'b0, res, lat);
        check_val("cos0_n0", res, 64'h10000, 0);
        check_val("cos0_n0_lat", longint'(lat), 3, 0);

        run_op(0, 'hFFFF, 8, 1'b0, res, lat);
        check_val("exp_max", res, 64'h2B7E1, 8);
        check_val("exp_max_lat", longint'(lat), 10, 0);

        run_op(0, 'h5A5A, 15, 1'b0, res, lat);
        check_val("n15", res, ref_model(0, 'h5A5A, 8), tol_of(8));
        check_val("n15_lat", longint'(lat), 10, 0);
        run_op(0, 'h5A5A, 8, 1'b0, res, lat);
        check_val("n8", res, ref_model(0, 'h5A5A, 8), tol_of(8));
        check_val("n8_lat", longint'(lat), 10, 0);

        run_op(1, 'hC000, 6, 1'b1, res, lat);
        expv = ref_model(1, 'hC000, 6);
        check_val("spam_res", res, expv, tol_of(6));
        check_val("spam_lat", longint'(lat), 8, 0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.Done) n_done++;
        end
        check_val("spam_extra_done", longint'(n_done), 0, 0);
        check_val("rbus_hold", longint'(bus.rBus), expv, tol_of(6));

        bus.start  = 1'b1;
        bus.xBus   = XW'('h8000);
        bus.func   = 2'(0);
        bus.nTerms = NW'(8);
        @(posedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_busy", longint'(bus.busy), 0, 0);
        check_val("midrst_done", longint'(bus.Done), 0, 0);
        check_val("midrst_rbus", longint'(bus.rBus), 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(0, 'h8000, 8, 1'b0, res, lat);
        check_val("post_rst_res", res, ref_model(0, 'h8000, 8), tol_of(8));
        check_val("post_rst_lat", longint'(lat), 10, 0);

        for (int i = 0; i < 40; i++) begin
            int fn;
            int xi;
            int nt;
            fn = int'($urandom_range(0, 3));
            xi = int'($urandom_range(0, 65535));
            nt = int'($urandom_range(0, 15));
            run_op(fn, xi, nt, 1'b0, res, lat);
            check_val($sformatf("rnd%0d_f%0d_x%0h_n%0d", i, fn, xi, nt), res,
                      ref_model(fn, xi, nt), tol_of(nt));
            check_val($sformatf("rnd%0d_lat", i), longint'(lat), longint'(clamp_n(nt) + 2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
